// File: rtl/fetch_ctrl_if.sv
// Instruction bus between the fetch controller and the memory side.
// Latency: wires only, no state.
// Backpressure: the bus stalls a request by holding iresp_addr_ok low.
interface fetch_ctrl_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_addr_ok,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_addr_ok,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request, buffers one word, handles redirects.
// Latency: word presented the cycle after the bus returns data (min 1 cycle from request).
// Backpressure: stall holds the buffered word in OUT; no new request is issued until it is taken.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    input  logic              stall,
    fetch_ctrl_if.master      ibus,
    output logic              out_valid,
    output logic [63:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic        capture;
    logic        deliver;

    // Next-state, next-pc and capture/deliver strobes; redirect always wins.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state)
            REQ: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    // Accepted but unanswered request must have its response dropped.
                    if (ibus.iresp_addr_ok && !ibus.iresp_data_ok)
                        state_nxt = DROP;
                    else
                        state_nxt = REQ;
                end else if (ibus.iresp_addr_ok && ibus.iresp_data_ok) begin
                    capture   = 1'b1;
                    pc_nxt    = pc + 64'd4;
                    state_nxt = OUT;
                end else if (ibus.iresp_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ibus.iresp_data_ok ? REQ : DROP;
                end else if (ibus.iresp_data_ok) begin
                    capture   = 1'b1;
                    pc_nxt    = pc + 64'd4;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end else if (!stall) begin
                    deliver   = 1'b1;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (redirect_valid)
                    pc_nxt = redirect_pc;
                if (ibus.iresp_data_ok)
                    state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    // State, pc, output buffer and delivered counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            out_pc    <= 64'd0;
            out_instr <= 32'd0;
            fetch_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                out_pc    <= pc;
                out_instr <= ibus.iresp_data;
            end
            if (deliver)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign ibus.ireq_valid = (state == REQ);
    assign ibus.ireq_addr  = pc;
    assign out_valid       = (state == OUT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl against a transaction-level reference model.
// Latency: model advanced once per clock, compared at the falling edge.
// Backpressure: stall and bus handshakes randomised alongside directed scenarios.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] fetch_cnt;

    logic        redirect_valid2;
    logic [63:0] redirect_pc2;
    logic        stall2;
    logic        out_valid2;
    logic [63:0] out_pc2;
    logic [31:0] out_instr2;
    logic [31:0] fetch_cnt2;

    int checks;
    int failures;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus2 ();

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ibus           (bus),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_cnt      (fetch_cnt)
    );

    fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .stall          (stall2),
        .ibus           (bus2),
        .out_valid      (out_valid2),
        .out_pc         (out_pc2),
        .out_instr      (out_instr2),
        .fetch_cnt      (fetch_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pending bus response (possibly stale) and a one-entry instruction buffer.
    logic [63:0] m_pc;
    bit          m_buf;
    logic [63:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    bit          m_pend;
    bit          m_stale;
    logic [31:0] m_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 64'h8000_0000;
        m_buf   = 0;
        m_pend  = 0;
        m_stale = 0;
        m_cnt   = 32'd0;
    endtask

    task automatic model_step(input bit a, input bit d, input bit s, input bit r,
                              input logic [63:0] rpc, input logic [31:0] data);
        if (m_buf) begin
            if (r) begin
                m_buf = 0;
                m_pc  = rpc;
            end else if (!s) begin
                m_buf = 0;
                m_cnt = m_cnt + 32'd1;
            end
        end else if (m_pend) begin
            if (d) begin
                m_pend = 0;
                if (r) begin
                    m_pc = rpc;
                end else if (!m_stale) begin
                    m_buf = 1; m_buf_pc = m_pc; m_buf_instr = data; m_pc = m_pc + 64'd4;
                end
                m_stale = 0;
            end else if (r) begin
                m_pc    = rpc;
                m_stale = 1;
            end
        end else begin
            if (a && d) begin
                if (r) m_pc = rpc;
                else begin
                    m_buf = 1; m_buf_pc = m_pc; m_buf_instr = data; m_pc = m_pc + 64'd4;
                end
            end else if (a) begin
                m_pend  = 1;
                m_stale = r;
                if (r) m_pc = rpc;
            end else if (r) begin
                m_pc = rpc;
            end
        end
    endtask

    task automatic compare();
        check_val("ireq_valid", 64'(bus.ireq_valid), 64'(!m_buf && !m_pend));
        check_val("ireq_addr", bus.ireq_addr, m_pc);
        check_val("out_valid", 64'(out_valid), 64'(m_buf));
        check_val("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
        if (m_buf) begin
            check_val("out_pc", out_pc, m_buf_pc);
            check_val("out_instr", 64'(out_instr), 64'(m_buf_instr));
        end
    endtask

    // Called just after a falling edge: drive inputs, advance model, compare at the next falling edge.
    task automatic cycle(input bit a, input bit d, input bit s, input bit r,
                         input logic [63:0] rpc, input logic [31:0] data);
        bus.iresp_addr_ok = a;
        bus.iresp_data_ok = d;
        bus.iresp_data    = data;
        stall             = s;
        redirect_valid    = r;
        redirect_pc       = rpc;
        model_step(a, d, s, r, rpc, data);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [31:0] saved_cnt;
        logic [63:0] rpc;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.iresp_addr_ok = 0; bus.iresp_data_ok = 0; bus.iresp_data = 32'd0;
        stall = 0; redirect_valid = 0; redirect_pc = 64'd0;
        bus2.iresp_addr_ok = 1; bus2.iresp_data_ok = 1; bus2.iresp_data = 32'h0000_0013;
        stall2 = 0; redirect_valid2 = 0; redirect_pc2 = 64'd0;
        model_reset();

        repeat (2) @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_pc", out_pc, 64'd0);
        check_val("rst_out_instr", 64'(out_instr), 64'd0);
        check_val("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        check_val("rst_ireq_addr", bus.ireq_addr, 64'h8000_0000);
        reset = 1'b1;
        compare();
        check_val("wrap_first_addr", bus2.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // Single-cycle fetch of a nop.
        cycle(1, 1, 0, 0, 64'd0, 32'h0000_0013);
        check_val("first_out_valid", 64'(out_valid), 64'd1);
        check_val("first_out_pc", out_pc, 64'h8000_0000);
        check_val("first_out_instr", 64'(out_instr), 64'h13);
        check_val("wrap_out_pc", out_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 0, 0, 0, 64'd0, 32'd0);
        check_val("second_addr", bus.ireq_addr, 64'h8000_0004);
        check_val("first_cnt", 64'(fetch_cnt), 64'd1);
        check_val("wrap_next_addr", bus2.ireq_addr, 64'd0);

        // Accept, wait three cycles for data, then hold under stall.
        cycle(1, 0, 0, 0, 64'd0, 32'd0);
        cycle(0, 0, 0, 0, 64'd0, 32'd0);
        cycle(0, 0, 0, 0, 64'd0, 32'd0);
        cycle(0, 1, 1, 0, 64'd0, 32'hDEAD_BEEF);
        cycle(0, 0, 1, 0, 64'd0, 32'd0);
        cycle(0, 0, 1, 0, 64'd0, 32'd0);
        check_val("stall_hold_instr", 64'(out_instr), 64'hDEAD_BEEF);
        cycle(0, 0, 0, 0, 64'd0, 32'd0);

        // Redirect while waiting; stale data two cycles later is dropped.
        cycle(1, 0, 0, 0, 64'd0, 32'd0);
        cycle(0, 0, 0, 1, 64'h8000_0100, 32'd0);
        check_val("drop_no_req", 64'(bus.ireq_valid), 64'd0);
        cycle(0, 0, 0, 0, 64'd0, 32'd0);
        cycle(0, 1, 0, 0, 64'd0, 32'h1111_1111);
        check_val("drop_no_out", 64'(out_valid), 64'd0);
        check_val("after_drop_addr", bus.ireq_addr, 64'h8000_0100);

        // Redirect while holding a stalled word.
        cycle(1, 1, 0, 0, 64'd0, 32'h2222_2222);
        cycle(0, 0, 1, 0, 64'd0, 32'd0);
        saved_cnt = fetch_cnt;
        cycle(0, 0, 1, 1, 64'h8000_0200, 32'd0);
        check_val("redir_out_valid", 64'(out_valid), 64'd0);
        check_val("redir_cnt", 64'(fetch_cnt), 64'(saved_cnt));
        check_val("redir_addr", bus.ireq_addr, 64'h8000_0200);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rpc = {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                  rpc, 32'($urandom));
        end

        // Async reset in the middle of a transaction.
        cycle(0, 0, 0, 1, 64'h8000_0400, 32'd0);
        while (m_buf || m_pend) cycle(0, 1, 0, 0, 64'd0, 32'd0);
        cycle(1, 1, 0, 0, 64'd0, 32'h3333_3333);
        cycle(0, 0, 0, 0, 64'd0, 32'd0);
        cycle(1, 0, 0, 0, 64'd0, 32'd0);
        #2 reset = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_out_pc", out_pc, 64'd0);
        check_val("arst_out_instr", 64'(out_instr), 64'd0);
        check_val("arst_cnt", 64'(fetch_cnt), 64'd0);
        check_val("arst_addr", bus.ireq_addr, 64'h8000_0000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        compare();
        cycle(0, 1, 0, 0, 64'd0, 32'h4444_4444);
        check_val("late_data_out", 64'(out_valid), 64'd0);
        check_val("late_data_addr", bus.ireq_addr, 64'h8000_0000);
        cycle(1, 1, 0, 0, 64'd0, 32'h5555_5555);
        cycle(0, 0, 0, 0, 64'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 redirect_valid  input  1  branch/exception redirect request.
REQ-005 redirect_pc  input  64  redirect target address.
REQ-006 stall  input  1  downstream not accepting the presented instruction.
REQ-007 ireq_valid  output  1  instruction bus request valid.
REQ-008 ireq_addr  output  64  instruction bus request address.
REQ-009 iresp_addr_ok  input  1  bus accepted the request this cycle.
REQ-010 iresp_data_ok  input  1  bus returns data this cycle.
REQ-011 iresp_data  input  32  returned instruction word.
REQ-012 out_valid  output  1  fetched instruction presented downstream.
REQ-013 out_pc  output  64  PC of presented instruction.
REQ-014 out_instr  output  32  presented instruction word.
REQ-015 fetch_cnt  output  32  delivered-instruction counter.

Function
REQ-016 FSM states SHALL be REQ, WAIT, OUT, DROP; one outstanding bus transaction max.
REQ-017 Internal pc register SHALL be 64 bits; increments by 4 with natural wrap at 2^64.
REQ-018 ireq_valid SHALL be 1 only in REQ; ireq_addr SHALL equal pc in every state.
REQ-019 In REQ, ireq_addr SHALL stay stable until iresp_addr_ok, except on redirect.
REQ-020 REQ, no redirect: addr_ok&data_ok -> OUT, capture out_pc<=pc, out_instr<=iresp_data, pc<=pc+4; addr_ok only -> WAIT; neither -> stay REQ.
REQ-021 WAIT, no redirect: data_ok -> OUT with same capture and pc<=pc+4; else stay.
REQ-022 out_valid SHALL be 1 exactly when state is OUT; out_pc/out_instr hold stable throughout OUT.
REQ-023 OUT, no redirect: stall=0 -> REQ and fetch_cnt+1; stall=1 -> stay OUT.
REQ-024 Redirect SHALL have priority over all other events in every state and SHALL load pc<=redirect_pc.
REQ-025 Redirect in REQ: addr_ok=0 or (addr_ok&data_ok) -> REQ; addr_ok=1,data_ok=0 -> DROP.
REQ-026 Redirect in WAIT: data_ok=1 -> REQ, data discarded; data_ok=0 -> DROP.
REQ-027 Redirect in OUT: buffered instruction discarded, fetch_cnt unchanged, -> REQ, regardless of stall.
REQ-028 DROP: ireq_valid=0; data_ok -> REQ, data discarded; redirect in DROP updates pc, stays DROP unless data_ok same cycle.
REQ-029 Discarded responses SHALL never reach out_valid/out_instr and SHALL not advance pc.
REQ-030 stall SHALL be ignored in states other than OUT.
REQ-031 fetch_cnt SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-032 iresp_data_ok outside WAIT/DROP/REQ-with-addr_ok SHALL be ignored.

Reset
REQ-033 reset=0 SHALL immediately force state REQ, pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, fetch_cnt=0, independent of clk.
REQ-034 Reset asserted mid-transaction SHALL abandon it; first post-reset cycle presents ireq_valid=1, ireq_addr=RESET_PC.

Verification
REQ-035 Release reset, bus answers addr_ok&data_ok=1 with 32'h0000_0013, stall=0 -> ireq_addr 8000_0000, next cycle out_valid=1 out_pc=8000_0000 out_instr=0000_0013, then ireq_addr 8000_0004, fetch_cnt=1.
REQ-036 addr_ok cycle 1, data_ok cycle 4, stall=1 for 3 cycles in OUT -> out_valid held 3+ cycles with unchanged out_pc/out_instr, ireq_valid=0 throughout WAIT/OUT.
REQ-037 Redirect to 64'h8000_0100 in WAIT, stale data_ok two cycles later -> DROP, no out_valid, then ireq_addr=8000_0100 with ireq_valid=1.
REQ-038 Redirect to 64'h8000_0200 while in OUT with stall=1 -> out_valid falls next cycle, fetch_cnt unchanged, ireq_addr=8000_0200.
REQ-039 reset asserted asynchronously during WAIT -> outputs zero before next edge; after release ireq_addr=8000_0000, late data_ok from old transaction not delivered.
REQ-040 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch completes -> next ireq_addr=64'h0 (wrap).
